// File: rtl/fifo_read_drain.sv
// rtl/fifo_read_drain.sv - FIFO read-side drain: credit-based read issue, 2-entry skid buffer, valid/ready output, word counter
module fifo_read_drain #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_read,
    input  logic                   rst,
    input  logic                   Drain_enable,
    input  logic                   Empty,
    input  logic [DATA_WIDTH-1:0]  DataOut,
    output logic                   Read_enable,
    output logic [DATA_WIDTH-1:0]  Out_data,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [COUNT_WIDTH-1:0] Words_out
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } occ_t;

    occ_t                  state;
    occ_t                  state_next;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            committed;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    assign pop      = Out_valid & Out_ready;
    assign Out_data = head;

    always_ff @(posedge clk_read) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S0: if (inflight) state_next = S1;
            S1: begin
                if (inflight && !pop) begin
                    state_next = S2;
                end else if (!inflight && pop) begin
                    state_next = S0;
                end
            end
            S2: if (pop && !inflight) state_next = S1;
            default: state_next = S0;
        endcase
    end

    // Words already owned (buffered or inflight) after this cycle's pop; a new read needs a free slot.
    always_comb begin
        Out_valid   = (state != S0);
        committed   = 2'(state) + 2'(inflight) - 2'(pop);
        Read_enable = !rst && Drain_enable && !Empty && (committed < 2'd2);
    end

    always_ff @(posedge clk_read) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            inflight  <= 1'b0;
            Words_out <= '0;
        end else begin
            inflight <= Read_enable;
            if (pop) begin
                Words_out <= Words_out + COUNT_WIDTH'(1);
            end
            case (state)
                S0: if (inflight) head <= DataOut;
                S1: begin
                    if (inflight) begin
                        if (pop) begin
                            head <= DataOut;
                        end else begin
                            tail <= DataOut;
                        end
                    end
                end
                S2: begin
                    if (pop) begin
                        head <= tail;
                        if (inflight) tail <= DataOut;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
